// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder and its lane aligner.
//   - dm_* access-size/sign codes driven by the core on req_dmtype
//   - dmr_state_t: responder FSM states, also exported on the debug port
//   - dm_misaligned(): alignment check for a given access size
package dmem_responder_pkg;

    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    typedef enum logic [1:0] {
        DMR_IDLE  = 2'd0,
        DMR_DRAIN = 2'd1,
        DMR_READ  = 2'd2,
        DMR_RESP  = 2'd3
    } dmr_state_t;

    // Undefined codes behave as a word access, so they need word alignment.
    function automatic logic dm_misaligned(input logic [2:0] dmtype, input logic [1:0] addr_lo);
        logic mis;
        case (dmtype)
            dm_byte, dm_byte_unsigned:         mis = 1'b0;
            dm_halfword, dm_halfword_unsigned: mis = addr_lo[0];
            default:                           mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core's MEM stage (master) and the responder (slave).
// Handshake: a request transfers on a clk edge where req_valid & req_ready are both 1;
// the master holds the payload stable while req_valid is high and req_ready is low.
// rsp_valid is a one-cycle pulse with no backpressure; rsp_fault and rsp_rdata are
// meaningful only while rsp_valid is 1.
//   req_valid/req_ready  request handshake
//   req_we               1 = store, 0 = load
//   req_addr             byte address
//   req_wdata            right-justified store data
//   req_dmtype           dm_* size/sign code
//   rsp_valid            load data or fault result present
//   rsp_rdata            extended load data (0 on fault)
//   rsp_fault            misaligned or out-of-range access
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_dmtype;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_dmtype,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_dmtype,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_responder_lane_align.sv
// dm_lane_align: combinational sub-word lane logic shared with the MEM stage.
//   dmtype      in  access size/sign code
//   addr_lo     in  byte offset within the word
//   wdata       in  right-justified store data
//   rword       in  full array word for a load
//   be          out store byte enables
//   wdata_lane  out store data replicated into every lane of its size
//   rdata_ext   out load data shifted down and sign/zero-extended
module dm_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  dmtype,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rword[{addr_lo, 3'b000} +: 8];
        sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
        case (dmtype)
            dm_byte, dm_byte_unsigned: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = (dmtype == dm_byte) ? {{24{sel_byte[7]}}, sel_byte}
                                                 : {24'h000000, sel_byte};
            end
            dm_halfword, dm_halfword_unsigned: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = (dmtype == dm_halfword) ? {{16{sel_half[15]}}, sel_half}
                                                     : {16'h0000, sel_half};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the core's data-memory port.
// Stores are posted into a circular write buffer and committed to the array in
// order, each holding the array for WRITE_LAT cycles. A load waits for the buffer
// to drain so it always observes every older store, then reads the array and
// returns extended data READ_LAT cycles after the read starts.
//   clk, reset   clock and asynchronous active-low reset
//   bus          slave side of dmem_responder_if
//   wbuf_empty   no posted stores pending
//   dbg_state    current FSM state
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int READ_LAT    = 2,
    parameter int WRITE_LAT   = 1,
    parameter int WBUF_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    dmem_responder_if.slave bus,
    output logic        wbuf_empty,
    output dmr_state_t  dbg_state
);

    localparam int IDX_W   = $clog2(DEPTH_WORDS);
    localparam int PW      = $clog2(WBUF_DEPTH);
    localparam int WC_W    = $clog2(WRITE_LAT + 1);
    localparam int RC_W    = $clog2(READ_LAT + 1);
    localparam int RD_LAST = (READ_LAT >= 2) ? READ_LAT - 2 : 0;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(WBUF_DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
        logic [3:0]       be;
    } wbuf_entry_t;

    logic [31:0] mem [0:DEPTH_WORDS-1];

    wbuf_entry_t wbuf_mem [WBUF_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [WC_W-1:0] wr_cnt;
    logic [RC_W-1:0] rd_cnt;

    dmr_state_t state_q, state_d, read_entry;
    logic ready_en;

    logic [IDX_W-1:0] lat_idx;
    logic [1:0]       lat_lo;
    logic [2:0]       lat_dmtype;
    logic             lat_fault;

    logic accept, req_fault, push, pop, wbuf_full;
    logic [2:0]  align_dmtype;
    logic [1:0]  align_lo;
    logic [3:0]  st_be;
    logic [31:0] st_data, ld_data;

    // With a single-cycle read the READ state is skipped entirely.
    assign read_entry = (READ_LAT == 1) ? DMR_RESP : DMR_READ;

    assign wbuf_full     = (count == FULL_CNT);
    assign wbuf_empty    = (count == '0);
    assign bus.req_ready = (state_q == DMR_IDLE) & ~wbuf_full & ready_en;
    assign accept        = bus.req_valid & bus.req_ready;
    assign req_fault     = dm_misaligned(bus.req_dmtype, bus.req_addr[1:0])
                         | ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign push          = accept & bus.req_we & ~req_fault;
    assign pop           = (count != '0) && (wr_cnt == WC_W'(WRITE_LAT - 1));
    assign dbg_state     = state_q;

    // Stores are only formed in IDLE from the live request; loads are extracted
    // later from the fields latched at accept.
    assign align_dmtype = (state_q == DMR_IDLE) ? bus.req_dmtype : lat_dmtype;
    assign align_lo     = (state_q == DMR_IDLE) ? bus.req_addr[1:0] : lat_lo;

    dm_lane_align u_align (
        .dmtype     (align_dmtype),
        .addr_lo    (align_lo),
        .wdata      (bus.req_wdata),
        .rword      (mem[lat_idx]),
        .be         (st_be),
        .wdata_lane (st_data),
        .rdata_ext  (ld_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            DMR_IDLE: begin
                if (accept) begin
                    if (req_fault)           state_d = DMR_RESP;
                    else if (!bus.req_we)    state_d = (count != '0) ? DMR_DRAIN : read_entry;
                end
            end
            DMR_DRAIN: begin
                if ((count == '0) || ((count == (PW + 1)'(1)) && pop)) state_d = read_entry;
            end
            DMR_READ: begin
                if (rd_cnt == RC_W'(RD_LAST)) state_d = DMR_RESP;
            end
            DMR_RESP: state_d = DMR_IDLE;
            default:  state_d = DMR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= DMR_IDLE;
            ready_en <= 1'b0;
            rd_cnt   <= '0;
        end else begin
            state_q  <= state_d;
            ready_en <= 1'b1;
            rd_cnt   <= (state_q == DMR_READ) ? rd_cnt + RC_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_idx    <= '0;
            lat_lo     <= '0;
            lat_dmtype <= dm_word;
            lat_fault  <= 1'b0;
        end else if (accept) begin
            lat_idx    <= bus.req_addr[IDX_W+1:2];
            lat_lo     <= bus.req_addr[1:0];
            lat_dmtype <= bus.req_dmtype;
            lat_fault  <= req_fault;
        end
    end

    // Write buffer bookkeeping; the head hold counter restarts whenever a new
    // entry becomes head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wr_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
            if (pop || (count == '0)) wr_cnt <= '0;
            else                      wr_cnt <= wr_cnt + WC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) wbuf_mem[wr_ptr] <= '{idx: bus.req_addr[IDX_W+1:2], data: st_data, be: st_be};
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            for (int i = 0; i < 4; i++) begin
                if (wbuf_mem[rd_ptr].be[i])
                    mem[wbuf_mem[rd_ptr].idx][8*i +: 8] <= wbuf_mem[rd_ptr].data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_fault <= 1'b0;
            bus.rsp_rdata <= '0;
        end else if (state_q == DMR_RESP) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_fault <= lat_fault;
            bus.rsp_rdata <= lat_fault ? 32'h0 : ld_data;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_fault <= 1'b0;
            bus.rsp_rdata <= '0;
        end
    end

endmodule
